alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: three-state issue controller for an external 16-bit ALU.
// Accepts one instruction, drives the ALU operands from an 8-entry register
// file, and writes the ALU result back on the edge that leaves WB.
module alu_issue_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  output logic [2:0]    alu_opcod,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_cout,
  input  logic          alu_lt,
  input  logic          alu_eq,
  input  logic          alu_gt,
  output logic          done,
  output logic          illegal,
  output logic [3:0]    flags,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_CLREQ = 3'd5;
  localparam logic [2:0] OP_ADDI  = 3'd6;
  localparam logic [2:0] OP_ILL   = 3'd7;

  state_t        state, state_nx;
  logic          ready_q, ready_nx;
  logic          done_q, done_nx;
  logic          ill_q, ill_nx;
  logic [15:0]   ir;
  logic [3:0]    flags_q;
  logic [DW-1:0] rf [8];

  logic          accept;
  logic [2:0]    op, rd, rs, rt;
  logic [6:0]    imm7;
  logic          legal_wb;
  logic          wr_en;
  logic [DW-1:0] wr_data;

  // Fields always come from the captured instruction, never the live bus.
  assign op   = ir[15:13];
  assign rd   = ir[12:10];
  assign rs   = ir[9:7];
  assign rt   = ir[6:4];
  assign imm7 = ir[6:0];

  assign accept = instr_valid && ready_q;

  // State, ready and the writeback pulses are registered so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= ready_nx;
      done_q  <= done_nx;
      ill_q   <= ill_nx;
    end
  end

  // Next state plus the registered outputs that belong to the upcoming state.
  always_comb begin
    state_nx = state;
    ready_nx = 1'b0;
    done_nx  = 1'b0;
    ill_nx   = 1'b0;
    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (accept) begin
          state_nx = EXEC;
          ready_nx = 1'b0;
        end
      end
      EXEC: begin
        state_nx = WB;
        done_nx  = (op != OP_ILL);
        ill_nx   = (op == OP_ILL);
      end
      WB: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Instruction register: loaded only on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (accept) begin
      ir <= instr;
    end
  end

  // ALU operand/opcode drive; quiet (all zero) while idle.
  always_comb begin
    alu_x     = '0;
    alu_y     = '0;
    alu_opcod = 3'd0;
    if (state != IDLE) begin
      alu_x = rf[rs];
      if (op == OP_ADDI) begin
        alu_y     = {{(DW-7){1'b0}}, imm7};
        alu_opcod = 3'd0;
      end else if (op == OP_ILL) begin
        alu_y     = rf[rt];
        alu_opcod = 3'd0;
      end else begin
        alu_y     = rf[rt];
        alu_opcod = op;
      end
    end
  end

  // CLREQ only clears on equality; R0 is never written so it stays zero.
  assign legal_wb = (state == WB) && (op != OP_ILL);
  assign wr_en    = legal_wb && (rd != 3'd0) && ((op != OP_CLREQ) || alu_eq);
  assign wr_data  = (op == OP_CLREQ) ? '0 : alu_out;

  // Register file write on the edge leaving WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_en) begin
      rf[rd] <= wr_data;
    end
  end

  // Flags track the most recent legal writeback only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'd0;
    end else if (legal_wb) begin
      flags_q <= {alu_cout, alu_lt, alu_eq, alu_gt};
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign illegal     = ill_q;
  assign flags       = flags_q;
  assign alu_cin     = 1'b0;
  assign dbg_data    = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors against alu_issue_ctrl with a behavioural
// ALU. Expected writebacks go into a queue; a monitor pops one per done/illegal
// pulse and checks the pulse, its latency, the written register and the flags.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0000;
  logic [15:0] alu_x, alu_y;
  logic [2:0]  alu_opcod;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_cout, alu_lt, alu_eq, alu_gt;
  logic        done, illegal;
  logic [3:0]  flags;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;

  typedef struct {
    bit          ill;
    logic [2:0]  rd;
    logic [15:0] val;
    logic [3:0]  flg;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  alu_issue_ctrl #(.DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_opcod  (alu_opcod),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_lt     (alu_lt),
    .alu_eq     (alu_eq),
    .alu_gt     (alu_gt),
    .done       (done),
    .illegal    (illegal),
    .flags      (flags),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: carry from ADD/SUB only, compare flags from SLT/CLREQ only.
  logic [16:0] sum17;
  always_comb begin
    sum17    = 17'd0;
    alu_out  = 16'd0;
    alu_cout = 1'b0;
    alu_lt   = 1'b0;
    alu_eq   = 1'b0;
    alu_gt   = 1'b0;
    case (alu_opcod)
      3'd0: begin
        sum17    = {1'b0, alu_x} + {1'b0, alu_y};
        alu_out  = sum17[15:0];
        alu_cout = sum17[16];
      end
      3'd1: begin
        sum17    = {1'b0, alu_x} + {1'b0, ~alu_y} + 17'd1;
        alu_out  = sum17[15:0];
        alu_cout = sum17[16];
      end
      3'd2: alu_out = alu_x & alu_y;
      3'd3: alu_out = alu_x | alu_y;
      3'd4: begin
        alu_out = (alu_x < alu_y) ? 16'd1 : 16'd0;
        alu_lt  = (alu_x < alu_y);
        alu_eq  = (alu_x == alu_y);
        alu_gt  = (alu_x > alu_y);
      end
      3'd5: begin
        alu_out = 16'd0;
        alu_lt  = (alu_x < alu_y);
        alu_eq  = (alu_x == alu_y);
        alu_gt  = (alu_x > alu_y);
      end
      default: alu_out = 16'd0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  function automatic logic [15:0] ri(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [6:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Issue one instruction, queue its expected writeback, check EXEC operands.
  task automatic issue(input logic [15:0] w, input bit ill, input logic [2:0] rd,
                       input logic [15:0] val, input logic [3:0] flg,
                       input logic [15:0] ex, input logic [15:0] ey, input logic [2:0] eop);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = w;
    e.ill = ill;
    e.rd  = rd;
    e.val = val;
    e.flg = flg;
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'hFFFF;
    chk("exec_ready_low", instr_ready, 0);
    if (!ill) begin
      chk($sformatf("alu_x_%h", w), alu_x, ex);
      chk($sformatf("alu_y_%h", w), alu_y, ey);
      chk($sformatf("alu_opcod_%h", w), alu_opcod, eop);
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: one scoreboard entry per done/illegal pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (done || illegal)) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: done=%b illegal=%b expected no pulse", done, illegal);
        end else begin
          e = sb.pop_front();
          $display("txn rd=%0d ill=%0b done=%0b illegal=%0b", e.rd, e.ill, done, illegal);
          chk("done", done, {31'd0, !e.ill});
          chk("illegal", illegal, {31'd0, e.ill});
          // Counted from the accepting (IDLE) cycle to the WB cycle.
          chk("latency", cyc - e.acc, 2);
          @(posedge clk);
          #1;
          dbg_addr = e.rd;
          #1;
          chk($sformatf("rf_r%0d", e.rd), dbg_data, e.val);
          chk("flags", flags, e.flg);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    exp_t e;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_flags", flags, 0);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_alu_y", alu_y, 0);
    chk("rst_alu_opcod", alu_opcod, 0);
    chk("alu_cin", alu_cin, 0);
    dbg_addr = 3'd1;
    #1;
    chk("rst_r1", dbg_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", instr_ready, 1);

    // ADDI / SUB / ADD with carry.
    issue(ri(3'd6, 3'd1, 3'd0, 7'd5), 0, 3'd1, 16'h0005, 4'b0000, 16'h0000, 16'h0005, 3'd0);
    issue(ri(3'd6, 3'd2, 3'd0, 7'd1), 0, 3'd2, 16'h0001, 4'b0000, 16'h0000, 16'h0001, 3'd0);
    issue(rr(3'd1, 3'd1, 3'd0, 3'd2), 0, 3'd1, 16'hFFFF, 4'b0000, 16'h0000, 16'h0001, 3'd1);
    issue(rr(3'd0, 3'd3, 3'd1, 3'd2), 0, 3'd3, 16'h0000, 4'b1000, 16'hFFFF, 16'h0001, 3'd0);

    // SLT both ways.
    issue(ri(3'd6, 3'd1, 3'd0, 7'd3), 0, 3'd1, 16'h0003, 4'b0000, 16'h0000, 16'h0003, 3'd0);
    issue(ri(3'd6, 3'd2, 3'd0, 7'd7), 0, 3'd2, 16'h0007, 4'b0000, 16'h0000, 16'h0007, 3'd0);
    issue(rr(3'd4, 3'd4, 3'd1, 3'd2), 0, 3'd4, 16'h0001, 4'b0100, 16'h0003, 16'h0007, 3'd4);
    issue(rr(3'd4, 3'd4, 3'd2, 3'd1), 0, 3'd4, 16'h0000, 4'b0001, 16'h0007, 16'h0003, 3'd4);

    // Build R5=0x1234 by doubling (rd==rs==rt uses the pre-write value).
    issue(ri(3'd6, 3'd5, 3'd0, 7'h12), 0, 3'd5, 16'h0012, 4'b0000, 16'h0000, 16'h0012, 3'd0);
    v = 16'h0012;
    for (int k = 0; k < 8; k++) begin
      issue(rr(3'd0, 3'd5, 3'd5, 3'd5), 0, 3'd5, v << 1, 4'b0000, v, v, 3'd0);
      v = v << 1;
    end
    issue(ri(3'd6, 3'd5, 3'd5, 7'h34), 0, 3'd5, 16'h1234, 4'b0000, 16'h1200, 16'h0034, 3'd0);

    // CLREQ equal clears, unequal leaves the register alone.
    issue(rr(3'd5, 3'd5, 3'd1, 3'd1), 0, 3'd5, 16'h0000, 4'b0010, 16'h0003, 16'h0003, 3'd5);
    issue(ri(3'd6, 3'd5, 3'd0, 7'h55), 0, 3'd5, 16'h0055, 4'b0000, 16'h0000, 16'h0055, 3'd0);
    issue(rr(3'd5, 3'd5, 3'd1, 3'd2), 0, 3'd5, 16'h0055, 4'b0100, 16'h0003, 16'h0007, 3'd5);

    // Illegal op: no write, flags keep the CLREQ value.
    issue(rr(3'd7, 3'd1, 3'd2, 3'd3), 1, 3'd1, 16'h0003, 4'b0100, 16'h0000, 16'h0000, 3'd0);

    // Write to R0 is dropped but the flags still update.
    issue(ri(3'd6, 3'd0, 3'd0, 7'd9), 0, 3'd0, 16'h0000, 4'b0000, 16'h0000, 16'h0009, 3'd0);

    // instr_valid held high: accept only every third cycle.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ri(3'd6, 3'd6, 3'd6, 7'd1);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("ready_held_%0d", k), instr_ready, (k % 3 == 0) ? 1 : 0);
      if (instr_ready) begin
        e.ill = 1'b0;
        e.rd  = 3'd6;
        e.val = 16'(k / 3 + 1);
        e.flg = 4'b0000;
        e.acc = cyc;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted in EXEC of ADDI r2: aborted, no pulse.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ri(3'd6, 3'd2, 3'd0, 7'd9);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("abort_exec_alu_y", alu_y, 16'h0009);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", instr_ready, 0);
    chk("abort_alu_y", alu_y, 0);
    repeat (2) @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_illegal", illegal, 0);
    dbg_addr = 3'd2;
    #1;
    chk("abort_r2", dbg_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", instr_ready, 1);
    chk("abort_r2_after", dbg_data, 0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
